// File: rtl/calc_pkg.sv
// Shared types and constants for the I2C calculator sequencer: opcode and FSM state
// encodings, the opcode limit and the byte returned to reads while a calculation is running.
package calc_pkg;

  localparam int         OP_MAX       = 6;
  localparam logic [7:0] TX_BUSY_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5
  } calc_op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_A    = 3'd1,
    ST_GET_B    = 3'd2,
    ST_LAUNCH   = 3'd3,
    ST_WAIT_ALU = 3'd4,
    ST_READY    = 3'd5
  } calc_state_t;

  function automatic logic state_is_busy(input calc_state_t s);
    return !((s == ST_IDLE) || (s == ST_READY));
  endfunction

endpackage

// File: rtl/calc_watchdog.sv
// Loadable down-counter bounding the ALU wait: loaded when the ALU is launched, flags expiry
// on the ALU_TMO-th counted cycle, disarmed by alu_done.
module calc_watchdog #(
  parameter int ALU_TMO = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic tick_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(ALU_TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  // Expiry lands on the cycle where the counter shows 1, i.e. the ALU_TMO-th tick after load.
  assign expired_o = armed_q && tick_i && (cnt_q == CW'(1));

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load_i) begin
      cnt_d   = CW'(ALU_TMO);
      armed_d = 1'b1;
    end else if (clear_i || expired_o) begin
      armed_d = 1'b0;
    end else if (armed_q && tick_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/i2c_calc_sequencer.sv
// Sequences one calculator transaction: opcode/A/B write frame, ALU start/done handshake,
// result served to I2C reads. Macro CALC_STATUS_EN prepends a status byte to the read sequence.
module i2c_calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ALU_TMO = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_valid_i,
  input  logic [DATA_W-1:0]   rx_data_i,
  input  logic                rx_first_i,
  input  logic                bus_stop_i,
  input  logic                tx_req_i,
  output logic [DATA_W-1:0]   tx_data_o,
  output logic                tx_valid_o,
  output logic                alu_start_o,
  output logic [2:0]          alu_op_o,
  output logic [DATA_W-1:0]   alu_a_o,
  output logic [DATA_W-1:0]   alu_b_o,
  input  logic                alu_done_i,
  input  logic [2*DATA_W-1:0] alu_result_i,
  output logic                busy_o,
  output logic                err_o,
  output logic [2:0]          dbg_state_o
);

  // ALU handshake: alu_start_o pulses for the single LAUNCH cycle; operands stay stable
  // until alu_done_i (one-cycle pulse, alu_result_i valid with it) or timeout abort.
  // Reads: tx_valid_o pulses exactly one cycle after each tx_req_i pulse.

`ifdef CALC_STATUS_EN
  localparam logic [1:0] IDX_LAST = 2'd2;
`else
  localparam logic [1:0] IDX_LAST = 2'd1;
`endif

  calc_state_t         state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                err_q, err_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic [1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]   rd_byte;

  logic opc_byte, opc_ok, data_byte, can_op, stop_abort, in_wait;
  logic op_load, op_bad, a_load, b_load, wd_expired;

  assign opc_byte   = rx_valid_i & rx_first_i;
  assign data_byte  = rx_valid_i & ~rx_first_i;
  assign opc_ok     = (rx_data_i[2:0] < 3'(OP_MAX)) && (rx_data_i[DATA_W-1:3] == '0);
  assign can_op     = (state_q == ST_IDLE) || (state_q == ST_GET_A) ||
                      (state_q == ST_GET_B) || (state_q == ST_READY);
  assign stop_abort = bus_stop_i && ((state_q == ST_GET_A) || (state_q == ST_GET_B));
  assign in_wait    = (state_q == ST_WAIT_ALU);
  assign op_load    = can_op & opc_byte & opc_ok & ~stop_abort;
  assign op_bad     = can_op & opc_byte & ~opc_ok;
  assign a_load     = (state_q == ST_GET_A) & data_byte & ~stop_abort;
  assign b_load     = (state_q == ST_GET_B) & data_byte & ~stop_abort;

  calc_watchdog #(.ALU_TMO(ALU_TMO)) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (state_q == ST_LAUNCH),
    .tick_i    (in_wait),
    .clear_i   (alu_done_i),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A STOP while collecting operands outranks any byte arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (opc_byte) state_d = opc_ok ? ST_GET_A : ST_IDLE;
      end
      ST_GET_A: begin
        if (stop_abort)     state_d = ST_IDLE;
        else if (opc_byte)  state_d = opc_ok ? ST_GET_A : ST_IDLE;
        else if (data_byte) state_d = ST_GET_B;
      end
      ST_GET_B: begin
        if (stop_abort)     state_d = ST_IDLE;
        else if (opc_byte)  state_d = opc_ok ? ST_GET_A : ST_IDLE;
        else if (data_byte) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_WAIT_ALU;
      ST_WAIT_ALU: begin
        if (alu_done_i)      state_d = ST_READY;
        else if (wd_expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_start_o = (state_q == ST_LAUNCH);
    busy_o      = state_is_busy(state_q);
    dbg_state_o = state_q;
  end

`ifdef CALC_STATUS_EN
  logic [DATA_W-1:0] status_byte;
  assign status_byte = DATA_W'({busy_o, err_q, 3'b000, op_q});

  always_comb begin
    case (idx_q)
      2'd0:    rd_byte = status_byte;
      2'd1:    rd_byte = result_q[2*DATA_W-1:DATA_W];
      default: rd_byte = result_q[DATA_W-1:0];
    endcase
  end
`else
  always_comb begin
    rd_byte = (idx_q == 2'd0) ? result_q[2*DATA_W-1:DATA_W] : result_q[DATA_W-1:0];
  end
`endif

  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    err_d      = err_q;
    result_d   = result_q;
    idx_d      = idx_q;
    tx_valid_d = tx_req_i;
    tx_data_d  = tx_data_q;
    if (tx_req_i) begin
      tx_data_d = busy_o ? DATA_W'(TX_BUSY_BYTE) : rd_byte;
      if (!busy_o) idx_d = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
    end
    if (op_load) begin
      op_d  = rx_data_i[2:0];
      idx_d = 2'd0;
      err_d = 1'b0;
    end
    if (op_bad || stop_abort) err_d = 1'b1;
    if (a_load) a_d = rx_data_i;
    if (b_load) b_d = rx_data_i;
    // Done beats a timeout expiring in the same cycle; stray writes while waiting only flag.
    if (in_wait) begin
      if (rx_valid_i) err_d = 1'b1;
      if (alu_done_i)      result_d = alu_result_i;
      else if (wd_expired) err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      err_q      <= 1'b0;
      result_q   <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      err_q      <= err_d;
      result_q   <= result_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign alu_op_o   = op_q;
  assign alu_a_o    = a_q;
  assign alu_b_o    = b_q;
  assign err_o      = err_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

endmodule
